hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: max consecutive dmem_busy_i cycles before error; legal range 1..65535.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rs1_q2, rs2_q2  input  5 each  source register numbers of the instruction in decode.
REQ-005 uses_rs1_q2, uses_rs2_q2  input  1 each  decode instruction actually reads rs1 / rs2.
REQ-006 rd_q3  input  5  destination register of the instruction in execute.
REQ-007 mem_ren_q3  input  1  instruction in execute is a load.
REQ-008 branch_taken_q4  input  1  branch in memory stage resolved taken; PC redirect this cycle.
REQ-009 dmem_busy_i  input  1  data memory cannot complete the current access this cycle.
REQ-010 pc_hold_o  output  1  PC register keeps its value.
REQ-011 q1q2_hold_o  output  1  q1q2 pipeline register keeps its value.
REQ-012 q2q3_bubble_o  output  1  q2q3 loads all-zero control (NOP) instead of decode outputs.
REQ-013 flush_o  output  3  bit0 q1q2, bit1 q2q3, bit2 q3q4 loaded with NOP on the next edge.
REQ-014 freeze_o  output  1  every pipeline register and the PC hold.
REQ-015 err_o  output  1  sticky memory-timeout error.

Function
REQ-016 FSM states RUN, MEM_WAIT, ERROR; all outputs combinational from state and current inputs.
REQ-017 RUN -> MEM_WAIT when dmem_busy_i=1; MEM_WAIT -> RUN when dmem_busy_i=0; MEM_WAIT -> ERROR when the wait counter reaches MEM_TIMEOUT; ERROR exits only via reset.
REQ-018 Wait counter: 16 bits, cleared in RUN, incremented each MEM_WAIT cycle, saturating.
REQ-019 freeze_o=1 whenever dmem_busy_i=1 or state=ERROR; while freeze_o=1 all other control outputs are 0.
REQ-020 Branch flush: if not frozen and branch_taken_q4=1, flush_o=3'b111 for that cycle; pc_hold_o=0.
REQ-021 Load-use: if not frozen, branch_taken_q4=0, mem_ren_q3=1, rd_q3!=0 and ((uses_rs1_q2 and rs1_q2==rd_q3) or (uses_rs2_q2 and rs2_q2==rd_q3)), assert pc_hold_o, q1q2_hold_o, q2q3_bubble_o for that cycle.
REQ-022 Priority: freeze > branch flush > load-use stall > none.
REQ-023 Branch coincident with busy: the frozen q4 keeps branch_taken_q4 high; flush occurs in the first non-busy cycle, with no extra storage.
REQ-024 Load-use stall is exactly one cycle per hazard; no stall for rd_q3=0 or non-load producers (forwarding covers them).
REQ-025 err_o=1 iff state=ERROR.

Reset
REQ-026 rst_n low asynchronously forces state RUN, wait counter 0, perf counters 0; outputs then follow REQ-019..REQ-022 from live inputs; err_o=0.
REQ-027 Reset mid-MEM_WAIT or in ERROR returns to RUN with no residual hold.

Configuration
REQ-028 Macro HAZARD_CTRL_PERF_EN defined: add outputs stall_cnt_o[31:0] (cycles with pc_hold_o or freeze_o) and flush_cnt_o[31:0] (cycles with flush_o!=0), both wrapping at 2^32; undefined: ports and counters absent, all other behaviour unchanged.

Structure
REQ-029 State encoding, flush_o bit indices and NOP control constant live in shared package core_pkg, also used by the pipeline registers.
REQ-030 Single optional sub-module hazard_perf holds the perf counters; the FSM and hazard decode stay in hazard_ctrl.

Verification
REQ-031 mem_ren_q3=1, rd_q3=5, uses_rs1_q2=1, rs1_q2=5 -> pc_hold_o=q1q2_hold_o=q2q3_bubble_o=1 for exactly one cycle.
REQ-032 Same as REQ-031 with rd_q3=0, or mem_ren_q3=0 -> no hold, no bubble.
REQ-033 branch_taken_q4=1 together with a load-use hazard -> flush_o=3'b111, pc_hold_o=0, q2q3_bubble_o=0.
REQ-034 dmem_busy_i=1 for 3 cycles with branch_taken_q4=1 -> freeze_o=1 and flush_o=0 for 3 cycles, then flush_o=3'b111 in cycle 4.
REQ-035 MEM_TIMEOUT=4, dmem_busy_i held high -> err_o=1 after the 4th MEM_WAIT cycle, stays 1 after busy drops, and clears only on rst_n.
REQ-036 With HAZARD_CTRL_PERF_EN: 2 load-use stalls and 1 branch flush -> stall_cnt_o=2, flush_cnt_o=1; rst_n pulse -> both 0.

Source files
------------

// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the pipeline control path: hazard FSM state encoding,
// flush-vector bit positions, the NOP control word that pipeline registers load
// on a bubble or flush, and the load-use hazard compare.
// No ports (package).
// -----------------------------------------------------------------------------
package core_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } hz_state_t;

    // Bit positions inside flush_o
    localparam int unsigned FLUSH_Q1Q2 = 0;
    localparam int unsigned FLUSH_Q2Q3 = 1;
    localparam int unsigned FLUSH_Q3Q4 = 2;
    localparam logic [2:0]  FLUSH_ALL  = 3'b111;

    // Control word carried by the pipeline registers; all-zero is a NOP
    typedef struct packed {
        logic       reg_we;
        logic       mem_ren;
        logic       mem_wen;
        logic       branch;
        logic [3:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // A load in execute whose destination is read by the decode instruction.
    // x0 is never a real dependency.
    function automatic logic load_use_hit(
        input logic       mem_ren,
        input logic [4:0] rd,
        input logic       uses_rs1,
        input logic [4:0] rs1,
        input logic       uses_rs2,
        input logic [4:0] rs2
    );
        return mem_ren && (rd != 5'd0) &&
               ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundles the hazard controller's pipeline-side signals.
//   master : pipeline side, drives register numbers / status, reads controls
//   slave  : hazard_ctrl side
// Optional perf counter outputs exist only with HAZARD_CTRL_PERF_EN defined.
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;
    logic [4:0] rs1_q2;
    logic [4:0] rs2_q2;
    logic       uses_rs1_q2;
    logic       uses_rs2_q2;
    logic [4:0] rd_q3;
    logic       mem_ren_q3;
    logic       branch_taken_q4;
    logic       dmem_busy_i;
    logic       pc_hold_o;
    logic       q1q2_hold_o;
    logic       q2q3_bubble_o;
    logic [2:0] flush_o;
    logic       freeze_o;
    logic       err_o;
`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
`endif

    modport master (
        output rs1_q2, rs2_q2, uses_rs1_q2, uses_rs2_q2, rd_q3, mem_ren_q3,
               branch_taken_q4, dmem_busy_i,
`ifdef HAZARD_CTRL_PERF_EN
        input  stall_cnt_o, flush_cnt_o,
`endif
        input  pc_hold_o, q1q2_hold_o, q2q3_bubble_o, flush_o, freeze_o, err_o
    );

    modport slave (
        input  rs1_q2, rs2_q2, uses_rs1_q2, uses_rs2_q2, rd_q3, mem_ren_q3,
               branch_taken_q4, dmem_busy_i,
`ifdef HAZARD_CTRL_PERF_EN
        output stall_cnt_o, flush_cnt_o,
`endif
        output pc_hold_o, q1q2_hold_o, q2q3_bubble_o, flush_o, freeze_o, err_o
    );
endinterface

// File: rtl/hazard_ctrl_perf.sv
// -----------------------------------------------------------------------------
// hazard_perf
// Free-running event counters for the hazard controller (only built with
// HAZARD_CTRL_PERF_EN). Both wrap at 2^32.
//   clk, rst_n  : clock, async active-low reset
//   stall_evt   : this cycle the front end is held (stall or freeze)
//   flush_evt   : this cycle at least one pipeline register is flushed
//   stall_cnt   : number of stall cycles
//   flush_cnt   : number of flush cycles
// -----------------------------------------------------------------------------
module hazard_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_evt,
    input  logic        flush_evt,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt) stall_cnt <= stall_cnt + 32'd1;
            if (flush_evt) flush_cnt <= flush_cnt + 32'd1;
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller: memory-wait freeze with timeout error, taken-
// branch flush and one-cycle load-use stall. Priority is
// freeze > branch flush > load-use stall. All outputs are combinational from
// the FSM state and the live inputs.
//   MEM_TIMEOUT : consecutive MEM_WAIT busy cycles tolerated before ERROR
//   clk, rst_n  : clock, async active-low reset
//   hz (slave)  : register numbers, load/branch/busy status in;
//                 pc_hold_o, q1q2_hold_o, q2q3_bubble_o, flush_o[2:0],
//                 freeze_o, err_o out
// Build option: define HAZARD_CTRL_PERF_EN to add stall_cnt_o / flush_cnt_o
// (hazard_perf sub-module).
// -----------------------------------------------------------------------------
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hz
);

    hz_state_t   state, state_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;

    logic       frozen;
    logic       pc_hold;
    logic       q1q2_hold;
    logic       q2q3_bubble;
    logic [2:0] flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        frozen       = 1'b0;
        pc_hold      = 1'b0;
        q1q2_hold    = 1'b0;
        q2q3_bubble  = 1'b0;
        flush        = 3'b000;

        case (state)
            ST_RUN: begin
                wait_cnt_nxt = '0;
                if (hz.dmem_busy_i) state_nxt = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (wait_cnt != 16'hFFFF) wait_cnt_nxt = wait_cnt + 16'd1;
                // wait_cnt+1 is the number of MEM_WAIT cycles including this one
                if (!hz.dmem_busy_i)
                    state_nxt = ST_RUN;
                else if (({1'b0, wait_cnt} + 17'd1) >= 17'(MEM_TIMEOUT))
                    state_nxt = ST_ERROR;
            end
            ST_ERROR: begin
                state_nxt = ST_ERROR;
            end
            default: begin
                state_nxt    = ST_RUN;
                wait_cnt_nxt = '0;
            end
        endcase

        frozen = hz.dmem_busy_i || (state == ST_ERROR);

        // A branch seen while frozen is not stored: the held q4 register keeps
        // branch_taken_q4 asserted, so the flush happens on the first free cycle.
        if (!frozen) begin
            if (hz.branch_taken_q4) begin
                flush[FLUSH_Q1Q2] = 1'b1;
                flush[FLUSH_Q2Q3] = 1'b1;
                flush[FLUSH_Q3Q4] = 1'b1;
            end else if (load_use_hit(hz.mem_ren_q3, hz.rd_q3,
                                      hz.uses_rs1_q2, hz.rs1_q2,
                                      hz.uses_rs2_q2, hz.rs2_q2)) begin
                pc_hold     = 1'b1;
                q1q2_hold   = 1'b1;
                q2q3_bubble = 1'b1;
            end
        end
    end

    assign hz.pc_hold_o     = pc_hold;
    assign hz.q1q2_hold_o   = q1q2_hold;
    assign hz.q2q3_bubble_o = q2q3_bubble;
    assign hz.flush_o       = flush;
    assign hz.freeze_o      = frozen;
    assign hz.err_o         = (state == ST_ERROR);

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    hazard_perf u_perf (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall_evt (pc_hold || frozen),
        .flush_evt (flush != 3'b000),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    assign hz.stall_cnt_o = stall_cnt;
    assign hz.flush_cnt_o = flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl (MEM_TIMEOUT = 4). Directed scenarios
// carry literal expectations; a random phase follows. A single compare process
// checks every cycle against a behavioural model that tracks only the length
// of the current busy run and a sticky error flag.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
    localparam int unsigned TMO = 4;

    logic clk;
    logic rst_n;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Literal expectations posted by the stimulus process
    bit         lit_en = 1'b0;
    string      lit_name = "";
    bit         lit_pc, lit_q12, lit_bub, lit_frz, lit_err;
    bit [2:0]   lit_fl;
    bit         lit_perf_en = 1'b0;
    bit [31:0]  lit_stall, lit_flc;

    // Behavioural model state
    int         m_run = 0;     // consecutive busy cycles seen so far
    bit         m_err = 1'b0;
    bit [31:0]  m_stall = 0;
    bit [31:0]  m_flc = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare process: every cycle, 2 time units after the falling edge
    always @(negedge clk) begin
        bit       frz, e_pc, hit;
        bit [2:0] e_fl;
        #2;
        if (!rst_n) begin
            m_run   = 0;
            m_err   = 1'b0;
            m_stall = 0;
            m_flc   = 0;
        end
        frz  = hz.dmem_busy_i || m_err;
        hit  = hz.mem_ren_q3 && (hz.rd_q3 != 0) &&
               ((hz.uses_rs1_q2 && hz.rs1_q2 == hz.rd_q3) ||
                (hz.uses_rs2_q2 && hz.rs2_q2 == hz.rd_q3));
        e_fl = (!frz && hz.branch_taken_q4) ? 3'b111 : 3'b000;
        e_pc = !frz && !hz.branch_taken_q4 && hit;

        chk("model.freeze",  hz.freeze_o,      frz);
        chk("model.err",     hz.err_o,         m_err);
        chk("model.flush",   hz.flush_o,       e_fl);
        chk("model.pc_hold", hz.pc_hold_o,     e_pc);
        chk("model.q1q2",    hz.q1q2_hold_o,   e_pc);
        chk("model.bubble",  hz.q2q3_bubble_o, e_pc);
`ifdef HAZARD_CTRL_PERF_EN
        chk("model.stall_cnt", hz.stall_cnt_o, m_stall);
        chk("model.flush_cnt", hz.flush_cnt_o, m_flc);
`endif
        if (lit_en) begin
            chk({lit_name, ".pc_hold"}, hz.pc_hold_o,     lit_pc);
            chk({lit_name, ".q1q2"},    hz.q1q2_hold_o,   lit_q12);
            chk({lit_name, ".bubble"},  hz.q2q3_bubble_o, lit_bub);
            chk({lit_name, ".flush"},   hz.flush_o,       lit_fl);
            chk({lit_name, ".freeze"},  hz.freeze_o,      lit_frz);
            chk({lit_name, ".err"},     hz.err_o,         lit_err);
`ifdef HAZARD_CTRL_PERF_EN
            if (lit_perf_en) begin
                chk({lit_name, ".stall_cnt"}, hz.stall_cnt_o, lit_stall);
                chk({lit_name, ".flush_cnt"}, hz.flush_cnt_o, lit_flc);
            end
`endif
        end

        // State advance at the coming rising edge
        if (rst_n) begin
            m_run = hz.dmem_busy_i ? m_run + 1 : 0;
            if (m_run >= int'(TMO) + 1) m_err = 1'b1;
            if (e_pc || frz) m_stall = m_stall + 1;
            if (e_fl != 0)   m_flc   = m_flc + 1;
        end
    end

    task automatic drive(input bit [4:0] rs1, input bit u1, input bit [4:0] rs2, input bit u2,
                         input bit [4:0] rd, input bit ren, input bit br, input bit busy);
        hz.rs1_q2 = rs1;  hz.uses_rs1_q2 = u1;
        hz.rs2_q2 = rs2;  hz.uses_rs2_q2 = u2;
        hz.rd_q3  = rd;   hz.mem_ren_q3  = ren;
        hz.branch_taken_q4 = br;
        hz.dmem_busy_i     = busy;
    endtask

    // Post literal expectations for the current cycle (compare runs at +2)
    task automatic expect_lit(input string name, input bit pc, input bit q12, input bit bub,
                              input bit [2:0] fl, input bit frz, input bit err);
        lit_name = name;
        lit_pc = pc; lit_q12 = q12; lit_bub = bub;
        lit_fl = fl; lit_frz = frz; lit_err = err;
        lit_en = 1'b1;
        #4;
        lit_en = 1'b0;
        lit_perf_en = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int burst;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        @(negedge clk);
        expect_lit("reset", 0, 0, 0, 3'b000, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use on rs1: one-cycle stall, gone when the pipeline advances
        @(negedge clk); drive(5, 1, 0, 0, 5, 1, 0, 0);
        expect_lit("lu_rs1", 1, 1, 1, 3'b000, 0, 0);
        @(negedge clk); drive(7, 1, 0, 0, 0, 0, 0, 0);
        expect_lit("lu_after", 0, 0, 0, 3'b000, 0, 0);
        // Load-use on rs2
        @(negedge clk); drive(1, 1, 9, 1, 9, 1, 0, 0);
        expect_lit("lu_rs2", 1, 1, 1, 3'b000, 0, 0);
        // rd = 0 and non-load producers never stall
        @(negedge clk); drive(0, 1, 0, 0, 0, 1, 0, 0);
        expect_lit("lu_rd0", 0, 0, 0, 3'b000, 0, 0);
        @(negedge clk); drive(5, 1, 0, 0, 5, 0, 0, 0);
        expect_lit("lu_noload", 0, 0, 0, 3'b000, 0, 0);
        // Match on a register the instruction does not read
        @(negedge clk); drive(5, 0, 0, 0, 5, 1, 0, 0);
        expect_lit("lu_unused", 0, 0, 0, 3'b000, 0, 0);

        // Branch beats load-use
        @(negedge clk); drive(5, 1, 0, 0, 5, 1, 1, 0);
        expect_lit("br_lu", 0, 0, 0, 3'b111, 0, 0);

        // Branch held during 3 busy cycles, flush on the 4th
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(5, 1, 0, 0, 5, 1, 1, 1);
            expect_lit("br_busy", 0, 0, 0, 3'b000, 1, 0);
        end
        @(negedge clk); drive(5, 1, 0, 0, 5, 1, 1, 0);
        expect_lit("br_release", 0, 0, 0, 3'b111, 0, 0);
        idle();

        // Timeout: 1 RUN busy cycle + 4 MEM_WAIT busy cycles, then ERROR
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 1);
            expect_lit("tmo_wait", 0, 0, 0, 3'b000, 1, 0);
        end
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 1);
        expect_lit("tmo_err", 0, 0, 0, 3'b000, 1, 1);
        @(negedge clk); drive(5, 1, 0, 0, 5, 1, 1, 0);
        expect_lit("tmo_sticky", 0, 0, 0, 3'b000, 1, 1);
        @(negedge clk); drive(5, 1, 0, 0, 5, 1, 0, 0);
        expect_lit("tmo_sticky2", 0, 0, 0, 3'b000, 1, 1);
        @(negedge clk);
        rst_n = 1'b0;
        drive(5, 1, 0, 0, 5, 1, 0, 0);
        expect_lit("tmo_reset", 1, 1, 1, 3'b000, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        expect_lit("tmo_after", 0, 0, 0, 3'b000, 0, 0);

        // Reset mid-MEM_WAIT leaves no residual hold
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_lit("mw_reset", 0, 0, 0, 3'b000, 0, 0);

`ifdef HAZARD_CTRL_PERF_EN
        // 2 stalls + 1 flush
        do_reset();
        @(negedge clk); drive(3, 1, 0, 0, 3, 1, 0, 0);
        @(negedge clk); drive(0, 0, 4, 1, 4, 1, 0, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0);
        lit_stall = 2; lit_flc = 1; lit_perf_en = 1'b1;
        expect_lit("perf", 0, 0, 0, 3'b000, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        lit_stall = 0; lit_flc = 0; lit_perf_en = 1'b1;
        expect_lit("perf_reset", 0, 0, 0, 3'b000, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        // Random phase
        burst = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 1) rst_n = 1'b0;
            else rst_n = 1'b1;
            if (burst == 0 && $urandom_range(0, 99) < 3) burst = $urandom_range(1, 8);
            hz.rs1_q2 = 5'($urandom_range(0, 3));
            hz.rs2_q2 = 5'($urandom_range(0, 3));
            hz.rd_q3  = 5'($urandom_range(0, 3));
            hz.uses_rs1_q2 = 1'($urandom_range(0, 1));
            hz.uses_rs2_q2 = 1'($urandom_range(0, 1));
            hz.mem_ren_q3  = 1'($urandom_range(0, 1));
            hz.branch_taken_q4 = ($urandom_range(0, 99) < 20);
            hz.dmem_busy_i = (burst > 0) || ($urandom_range(0, 99) < 15);
            if (burst > 0) burst--;
        end

        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #4;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
